// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every handshake and bus signal of the two-port memory arbiter.
// It covers the instruction-fetch port (i_*), the data port (d_*), the
// pipeline stall outputs, the single-port memory side (mem_*) and the sticky
// timeout flag (err).
//
// Modports:
//   slave  - the arbiter itself. It receives the CPU requests and the memory
//            responses, and drives the acks, read data, stalls, memory
//            request and err.
//   master - the environment around the arbiter (CPU ports plus the memory),
//            with every direction reversed.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        i_stall;
  logic        d_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, i_stall, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, i_stall, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between an instruction-fetch port and a data
// port. Only one memory access is in flight at a time. The memory request is
// registered and held stable until the memory acks. Completion is returned to
// the winning port as a one-cycle ack, together with the read data.
//
// Arbitration: the data port normally wins. If the previous grant went to
// data and a fetch is pending, the fetch wins instead, so fetches are never
// starved. A port whose ack is high in this cycle is not granted again in the
// same cycle.
//
// Ports:
//   clock, reset - single clock; synchronous active-high reset
//   bus (slave)  - i_* fetch port, d_* data port, i_stall/d_stall,
//                  mem_* memory side, err sticky timeout flag
// Parameter:
//   TIMEOUT_CYC  - ack-wait limit (1..15); only meaningful with the timeout
//
// Optional feature: define ARB_TIMEOUT_EN to add a 4-bit ack-wait counter.
// When the memory does not ack in time, the transaction is aborted with read
// data 32'hDEADBEEF and err is set. Without the macro the arbiter waits
// forever and err is tied to 0.
module mem_port_arbiter #(
  parameter logic [3:0] TIMEOUT_CYC = 4'd15
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t      state, state_nx;
  logic        last_d, last_d_nx;
  logic        mem_req_q, mem_req_nx;
  logic        mem_we_q, mem_we_nx;
  logic [31:0] mem_addr_q, mem_addr_nx;
  logic [31:0] mem_wdata_q, mem_wdata_nx;
  logic        i_ack_q, i_ack_nx;
  logic        d_ack_q, d_ack_nx;
  logic [31:0] i_rdata_q, i_rdata_nx;
  logic [31:0] d_rdata_q, d_rdata_nx;
  logic        d_elig, i_elig, grant_d, grant_i;

`ifdef ARB_TIMEOUT_EN
  logic [3:0]  tmo_cnt, tmo_cnt_nx;
  logic        err_q, err_nx;
`endif

  // A port being acked this cycle still has its req high (the requester has
  // not yet seen the ack), so it is masked out to avoid serving it twice.
  assign d_elig  = bus.d_req & ~d_ack_q;
  assign i_elig  = bus.i_req & ~i_ack_q;
  assign grant_d = d_elig & ~(last_d & i_elig);
  assign grant_i = i_elig & ~grant_d;

  // State and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      last_d      <= last_d_nx;
      mem_req_q   <= mem_req_nx;
      mem_we_q    <= mem_we_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_wdata_q <= mem_wdata_nx;
      i_ack_q     <= i_ack_nx;
      d_ack_q     <= d_ack_nx;
      i_rdata_q   <= i_rdata_nx;
      d_rdata_q   <= d_rdata_nx;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_nx;
      err_q       <= err_nx;
`endif
    end
  end

  // Next-state logic. Every registered output holds its value unless a grant,
  // a completion or a timeout changes it. The acks default to 0 so that they
  // are single-cycle pulses.
  always_comb begin
    state_nx     = state;
    last_d_nx    = last_d;
    mem_req_nx   = mem_req_q;
    mem_we_nx    = mem_we_q;
    mem_addr_nx  = mem_addr_q;
    mem_wdata_nx = mem_wdata_q;
    i_ack_nx     = 1'b0;
    d_ack_nx     = 1'b0;
    i_rdata_nx   = i_rdata_q;
    d_rdata_nx   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_nx   = tmo_cnt;
    err_nx       = err_q;
`endif

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nx     = BUSY_D;
          last_d_nx    = 1'b1;
          mem_req_nx   = 1'b1;
          mem_we_nx    = bus.d_we;
          mem_addr_nx  = bus.d_addr;
          mem_wdata_nx = bus.d_wdata;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_nx   = '0;
`endif
        end else if (grant_i) begin
          state_nx     = BUSY_I;
          last_d_nx    = 1'b0;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = bus.i_addr;
          mem_wdata_nx = '0;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_nx   = '0;
`endif
        end
      end

      BUSY_D, BUSY_I: begin
        // A memory ack wins over a timeout that expires in the same cycle.
        if (bus.mem_ack) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          if (state == BUSY_D) begin
            d_ack_nx   = 1'b1;
            d_rdata_nx = bus.mem_rdata;
          end else begin
            i_ack_nx   = 1'b1;
            i_rdata_nx = bus.mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt == TIMEOUT_CYC) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          err_nx     = 1'b1;
          if (state == BUSY_D) begin
            d_ack_nx   = 1'b1;
            d_rdata_nx = 32'hDEADBEEF;
          end else begin
            i_ack_nx   = 1'b1;
            i_rdata_nx = 32'hDEADBEEF;
          end
        end else begin
          tmo_cnt_nx = tmo_cnt + 4'd1;
        end
`endif
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_stall   = bus.i_req & ~i_ack_q;
  assign bus.d_stall   = bus.d_req & ~d_ack_q;

`ifdef ARB_TIMEOUT_EN
  assign bus.err = err_q;
`else
  // The timeout limit has no function in this build. It is folded into a
  // deliberately unused net so that the parameter still counts as consumed.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign bus.err            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed, self-checking bench for mem_port_arbiter. Inputs are driven and
// outputs are sampled on the falling clock edge, away from the active edge.
// The DUT is built with TIMEOUT_CYC = 3. When ARB_TIMEOUT_EN is defined, the
// timeout path is exercised; otherwise the bench checks that the arbiter
// waits forever.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef ARB_TIMEOUT_EN
  // With a limit of 3, the 4th busy cycle is the last one; an ack there wins.
  localparam int STORE_WAIT = 4;
`else
  localparam int STORE_WAIT = 5;
`endif

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT_CYC(4'd3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic test_reset;
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h %h expected all zero",
               bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    reset = 1'b0;
  endtask

  // Both ports hold their requests; each access sees mem_ack in its 2nd cycle.
  task automatic test_back_to_back;
    logic        exp_d;
    logic [31:0] exp_addr, exp_data, got_data;
    @(negedge clock);
    bus.i_req = 1; bus.i_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.d_wdata = 0;
    for (int k = 0; k < 4; k++) begin
      exp_d    = (k % 2 == 0);
      exp_addr = exp_d ? 32'h200 : 32'h100;
      exp_data = 32'hA000_0000 + 32'(k);
      for (int c = 0; c < 2; c++) begin
        @(negedge clock);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.mem_addr} !== {4'b1000, exp_addr}) begin
          errors++;
          $display("[TB] FAIL b2b_busy k=%0d c=%0d: got req/we/iack/dack=%b addr=%h expected 1000 addr=%h",
                   k, c, {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack}, bus.mem_addr, exp_addr);
        end
      end
      bus.mem_ack = 1; bus.mem_rdata = exp_data;
      @(negedge clock);
      checks++;
      if ({bus.i_ack, bus.d_ack, bus.mem_req} !== {~exp_d, exp_d, 1'b0}) begin
        errors++;
        $display("[TB] FAIL b2b_ack k=%0d: got iack/dack/req=%b expected %b",
                 k, {bus.i_ack, bus.d_ack, bus.mem_req}, {~exp_d, exp_d, 1'b0});
      end
      got_data = exp_d ? bus.d_rdata : bus.i_rdata;
      checks++;
      if (got_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL b2b_rdata k=%0d: got %h expected %h", k, got_data, exp_data);
      end
      bus.mem_ack = 0;
      if (k == 3) begin
        bus.i_req = 0; bus.d_req = 0;
      end
    end
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.i_ack, bus.d_ack} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL b2b_quiet: got req/iack/dack=%b expected 000",
               {bus.mem_req, bus.i_ack, bus.d_ack});
    end
  endtask

  // Load with the memory acking in the first mem_req cycle.
  task automatic test_load;
    @(negedge clock);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.d_wdata = 0;
    #1;
    checks++;
    if (bus.d_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_stall_req: got %b expected 1", bus.d_stall);
    end
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.d_ack, bus.mem_addr} !== {3'b100, 32'h40}) begin
      errors++;
      $display("[TB] FAIL load_issue: got req/we/dack=%b addr=%h expected 100 addr=00000040",
               {bus.mem_req, bus.mem_we, bus.d_ack}, bus.mem_addr);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h1234;
    @(negedge clock);
    checks++;
    if ({bus.d_ack, bus.i_ack, bus.mem_req, bus.d_stall} !== 4'b1000 || bus.d_rdata !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL load_done: got dack/iack/req/stall=%b rdata=%h expected 1000 rdata=00001234",
               {bus.d_ack, bus.i_ack, bus.mem_req, bus.d_stall}, bus.d_rdata);
    end
    bus.mem_ack = 0; bus.d_req = 0;
    @(negedge clock);
    checks++;
    if ({bus.d_ack, bus.mem_req} !== 2'b00 || bus.d_rdata !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL load_hold: got dack/req=%b rdata=%h expected 00 rdata=00001234",
               {bus.d_ack, bus.mem_req}, bus.d_rdata);
    end
  endtask

  // Store whose ack arrives in the last of STORE_WAIT busy cycles.
  task automatic test_store;
    @(negedge clock);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFE0001;
    for (int c = 1; c <= STORE_WAIT; c++) begin
      @(negedge clock);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.d_stall, bus.d_ack, bus.mem_addr, bus.mem_wdata} !==
          {4'b1110, 32'h80, 32'hCAFE0001}) begin
        errors++;
        $display("[TB] FAIL store_hold c=%0d: got req/we/stall/ack=%b addr=%h wdata=%h expected 1110 00000080 cafe0001",
                 c, {bus.mem_req, bus.mem_we, bus.d_stall, bus.d_ack}, bus.mem_addr, bus.mem_wdata);
      end
      if (c == STORE_WAIT) begin
        bus.mem_ack = 1; bus.mem_rdata = 32'h5555AAAA;
      end
    end
    @(negedge clock);
    checks++;
    if ({bus.d_ack, bus.mem_req, bus.d_stall, bus.err} !== 4'b1000 || bus.d_rdata !== 32'h5555AAAA) begin
      errors++;
      $display("[TB] FAIL store_done: got ack/req/stall/err=%b rdata=%h expected 1000 rdata=5555aaaa",
               {bus.d_ack, bus.mem_req, bus.d_stall, bus.err}, bus.d_rdata);
    end
    bus.mem_ack = 0; bus.d_req = 0; bus.d_we = 0;
  endtask

  // The fetcher withdraws its request mid-access; the access still completes.
  task automatic test_drop;
    @(negedge clock);
    bus.i_req = 1; bus.i_addr = 32'h300;
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h300}) begin
      errors++;
      $display("[TB] FAIL drop_issue: got req=%b addr=%h expected 1 00000300", bus.mem_req, bus.mem_addr);
    end
    bus.i_req = 0;
    #1;
    checks++;
    if (bus.i_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_stall: got %b expected 0", bus.i_stall);
    end
    @(negedge clock);
    bus.mem_ack = 1; bus.mem_rdata = 32'h7777;
    @(negedge clock);
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.mem_req} !== 3'b100 || bus.i_rdata !== 32'h7777) begin
      errors++;
      $display("[TB] FAIL drop_done: got iack/dack/req=%b rdata=%h expected 100 rdata=00007777",
               {bus.i_ack, bus.d_ack, bus.mem_req}, bus.i_rdata);
    end
    bus.mem_ack = 0;
  endtask

  // A stray memory ack while idle must be ignored.
  task automatic test_idle_ack;
    @(negedge clock);
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if ({bus.i_ack, bus.d_ack, bus.mem_req} !== 3'b000 ||
          bus.i_rdata !== 32'h7777 || bus.d_rdata !== 32'h5555AAAA) begin
        errors++;
        $display("[TB] FAIL idle_ack c=%0d: got iack/dack/req=%b irdata=%h drdata=%h expected 000 00007777 5555aaaa",
                 c, {bus.i_ack, bus.d_ack, bus.mem_req}, bus.i_rdata, bus.d_rdata);
      end
    end
    bus.mem_ack = 0;
  endtask

`ifdef ARB_TIMEOUT_EN
  // A fetch that is never acked times out after the 4th busy cycle.
  task automatic test_timeout;
    @(negedge clock);
    bus.i_req = 1; bus.i_addr = 32'h500;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      checks++;
      if ({bus.mem_req, bus.i_ack, bus.err} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL tmo_wait c=%0d: got req/iack/err=%b expected 100", c, {bus.mem_req, bus.i_ack, bus.err});
      end
    end
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.i_ack, bus.err} !== 3'b011 || bus.i_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL tmo_fire: got req/iack/err=%b rdata=%h expected 011 deadbeef",
               {bus.mem_req, bus.i_ack, bus.err}, bus.i_rdata);
    end
    bus.i_req = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
    @(negedge clock);
    bus.mem_ack = 1; bus.mem_rdata = 32'h99;
    @(negedge clock);
    checks++;
    if ({bus.d_ack, bus.err} !== 2'b11 || bus.d_rdata !== 32'h99) begin
      errors++;
      $display("[TB] FAIL tmo_sticky: got dack/err=%b rdata=%h expected 11 00000099",
               {bus.d_ack, bus.err}, bus.d_rdata);
    end
    bus.mem_ack = 0; bus.d_req = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_clear: got err=%b expected 0", bus.err);
    end
  endtask
`else
  // Without the timeout, a fetch waits for as long as the memory takes.
  task automatic test_wait_forever;
    @(negedge clock);
    bus.i_req = 1; bus.i_addr = 32'h500;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      checks++;
      if ({bus.mem_req, bus.i_ack, bus.err} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL wait_busy c=%0d: got req/iack/err=%b expected 100", c, {bus.mem_req, bus.i_ack, bus.err});
      end
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h600D;
    @(negedge clock);
    checks++;
    if ({bus.i_ack, bus.mem_req, bus.err} !== 3'b100 || bus.i_rdata !== 32'h600D) begin
      errors++;
      $display("[TB] FAIL wait_done: got iack/req/err=%b rdata=%h expected 100 0000600d",
               {bus.i_ack, bus.mem_req, bus.err}, bus.i_rdata);
    end
    bus.mem_ack = 0; bus.i_req = 0;
  endtask
`endif

  // Reset during a fetch abandons it: no ack, everything back to zero.
  task automatic test_reset_busy;
    @(negedge clock);
    bus.i_req = 1; bus.i_addr = 32'h700;
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h700}) begin
      errors++;
      $display("[TB] FAIL rstbusy_issue: got req=%b addr=%h expected 1 00000700", bus.mem_req, bus.mem_addr);
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err} !== 5'b0 ||
        {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL rstbusy_clear: got ctrl=%b addr=%h wdata=%h irdata=%h drdata=%h expected all zero",
               {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err},
               bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    reset = 0; bus.i_req = 0;
    @(negedge clock);
    checks++;
    if ({bus.i_ack, bus.mem_req} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rstbusy_after: got iack/req=%b expected 00", {bus.i_ack, bus.mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_store();
    test_drop();
    test_idle_ack();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, ack-wait limit in cycles; 4-bit range 1..15; used only under Configuration.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-005 i_addr  input  32  fetch address (PC).
REQ-006 i_ack  output  1  one-cycle pulse, fetch complete.
REQ-007 i_rdata  output  32  fetched word, valid in the i_ack cycle and held until the next i_ack.
REQ-008 d_req  input  1  data request (MemRead or MemWrite), held until d_ack.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data address (ALU result).
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  one-cycle pulse, data access complete.
REQ-013 d_rdata  output  32  load word, valid in the d_ack cycle and held until the next d_ack.
REQ-014 i_stall  output  1  i_req & ~i_ack, combinational; freezes PC and IF/ID.
REQ-015 d_stall  output  1  d_req & ~d_ack, combinational; freezes the whole pipeline.
REQ-016 mem_req  output  1  request to the single-port memory, registered.
REQ-017 mem_we  output  1  write enable to memory, registered.
REQ-018 mem_addr  output  32  memory address, registered.
REQ-019 mem_wdata  output  32  memory write data, registered.
REQ-020 mem_ack  input  1  memory completion, one cycle; may arrive in the first mem_req cycle.
REQ-021 mem_rdata  input  32  read data, valid when mem_ack = 1.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 The FSM SHALL have three states: IDLE, BUSY_D and BUSY_I.
REQ-024 In IDLE the FSM SHALL make one grant per cycle: the data port wins, except when the previous grant was data and i_req = 1, in which case the instruction port wins. This alternation prevents fetch starvation.
REQ-025 On a grant the FSM SHALL latch the winning port's addr, we and wdata into mem_addr, mem_we and mem_wdata (fetch: mem_we = 0), set mem_req = 1 and enter the matching BUSY state, all in the same edge.
REQ-026 In BUSY_x, mem_req and the mem_* outputs SHALL remain stable until the cycle in which mem_ack = 1.
REQ-027 On mem_ack in BUSY_x, at the next edge the FSM SHALL:
- capture mem_rdata into x_rdata (d_rdata is also updated for stores);
- pulse x_ack for one cycle;
- clear mem_req;
- return to IDLE.
REQ-028 Minimum latency SHALL be 2 cycles: x_req sampled at edge 0, mem_req high after edge 0, mem_ack in that cycle, x_ack high after edge 1.
REQ-029 In the cycle x_ack = 1, IDLE SHALL NOT regrant port x. The next grant to x occurs at the earliest one cycle later, so a still-high req from a stalled requester is not double-served.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 If the requester drops x_req mid-transaction, the memory access SHALL still complete and x_ack SHALL still pulse.
REQ-032 At most one of i_ack or d_ack SHALL be high in any cycle.

Reset
REQ-033 While reset = 1 at an edge, the block SHALL set:
- state to IDLE;
- mem_req, mem_we, i_ack, d_ack and err to 0;
- mem_addr, mem_wdata, i_rdata and d_rdata to 0;
- the last-grant record to instruction.
REQ-034 Reset during BUSY_x SHALL abandon the transaction: mem_req = 0 after the edge and no x_ack is issued.

Configuration
REQ-035 With macro ARB_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without mem_ack.
REQ-036 When the counter reaches TIMEOUT_CYC, the block SHALL at the next edge:
- clear mem_req;
- pulse x_ack with x_rdata = 32'hDEADBEEF;
- set err = 1;
- return to IDLE.
REQ-037 mem_ack arriving in the same cycle as the counter reaching TIMEOUT_CYC SHALL take precedence, giving normal completion with err unchanged.
REQ-038 Without ARB_TIMEOUT_EN, BUSY_x SHALL wait indefinitely, err SHALL be constant 0, and the counter SHALL not exist.

Verification
REQ-039 Load: d_req = 1, d_we = 0, d_addr = 32'h40, mem_ack in the first mem_req cycle with mem_rdata = 32'h1234 -> mem_addr = 32'h40, mem_we = 0, d_ack pulses 2 cycles after request with d_rdata = 32'h1234.
REQ-040 Simultaneous i_req and d_req held high, mem_ack on 2nd cycle of each access -> grant order data, instruction, data, instruction; no port acked twice per request.
REQ-041 Store: d_we = 1, d_addr = 32'h80, d_wdata = 32'hCAFE0001, mem_ack delayed 5 cycles -> mem_req, mem_we = 1, mem_addr and mem_wdata stable for 5 cycles; d_stall = 1 until d_ack.
REQ-042 Reset asserted in BUSY_I before mem_ack -> mem_req = 0 next cycle, no i_ack, state IDLE, all outputs 0.
REQ-043 With ARB_TIMEOUT_EN and TIMEOUT_CYC = 3, fetch with mem_ack never asserted -> i_ack with i_rdata = 32'hDEADBEEF, err = 1 and held through later normal transactions until reset.
REQ-044 mem_ack pulsed in IDLE with no requests -> no ack outputs, state unchanged.
